// File: rtl/frame_zoom_stream.sv
// Centre digital zoom: buffers one raster frame, crops a centred W/Z x H/Z window and
// replays it upscaled by nearest-neighbour replication as a valid/ready stream.
module frame_zoom_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int MAX_ZOOM   = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            zoom_sel,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_sof,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_sof,
    output logic                  out_eol,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int PIXELS = IMG_WIDTH * IMG_HEIGHT;
    localparam int AW     = $clog2(PIXELS);
    localparam int XW     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int YW     = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int ZW     = 4;
    localparam int ZN     = 2 ** ZW;

    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
    localparam logic [AW-1:0] ROW_STEP = AW'(IMG_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        CALC,
        DRAIN
    } state_t;

    state_t state;

    // Crop origin per zoom factor, folded to constants at elaboration; illegal factors map to Z=1.
    logic [XW-1:0] x0_tab   [ZN];
    logic [YW-1:0] y0_tab   [ZN];
    logic [AW-1:0] base_tab [ZN];

    for (genvar z = 0; z < ZN; z++) begin : g_tab
        localparam int ZE = (z >= 1 && z <= MAX_ZOOM) ? z : 1;
        localparam int X0 = (IMG_WIDTH - IMG_WIDTH / ZE) / 2;
        localparam int Y0 = (IMG_HEIGHT - IMG_HEIGHT / ZE) / 2;
        assign x0_tab[z]   = XW'(X0);
        assign y0_tab[z]   = YW'(Y0);
        assign base_tab[z] = AW'(Y0 * IMG_WIDTH);
    end

    logic [ZW-1:0] zsel_ext;
    logic [ZW-1:0] zl_req;
    logic [ZW-1:0] zl;
    logic [ZW-1:0] zl_max;

    assign zsel_ext = ZW'(zoom_sel);
    assign zl_req   = (zsel_ext != '0 && zsel_ext <= ZW'(MAX_ZOOM)) ? zsel_ext : ZW'(1);
    assign zl_max   = zl - ZW'(1);

    // Fill side
    logic [XW-1:0] fx;
    logic [YW-1:0] fy;
    logic [AW-1:0] wr_addr;
    logic          in_fire;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;

    assign in_fire   = in_valid && in_ready;
    assign mem_we    = in_fire && (state == FILL || in_sof);
    assign mem_waddr = in_sof ? '0 : wr_addr;

    // Drain side: counters describe the next pixel to be fetched from the frame memory
    logic [XW-1:0] ox;
    logic [YW-1:0] oy;
    logic [ZW-1:0] rep_x;
    logic [ZW-1:0] rep_y;
    logic [XW-1:0] x0_q;
    logic [XW-1:0] src_x;
    logic [YW-1:0] src_y;
    logic [AW-1:0] row_base;
    logic          issued_all;
    logic          out_last;
    logic          out_fire;
    logic          load;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          pend_last_x;
    logic          pend_last_y;

    logic [DATA_WIDTH-1:0] mem [PIXELS];
    logic [DATA_WIDTH-1:0] rd_q;

    assign out_fire    = out_valid && out_ready;
    assign load        = (state == DRAIN) && (!out_valid || out_ready);
    assign rd_en       = load && !issued_all;
    assign rd_addr     = row_base + AW'(src_x);
    assign pend_last_x = (ox == X_LAST);
    assign pend_last_y = (oy == Y_LAST);

    // The read register doubles as the output data register; masking keeps out_data at 0 in reset.
    assign out_data = out_valid ? rd_q : '0;

    // NOTE: the frame memory and its read register carry no reset so they map onto block RAM;
    // nothing downstream observes their contents before a frame has been written.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= in_data;
        end
        if (rd_en) begin
            rd_q <= mem[rd_addr];
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order inside the block.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            out_eol    <= 1'b0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            zl         <= ZW'(1);
            fx         <= '0;
            fy         <= '0;
            wr_addr    <= '0;
            ox         <= '0;
            oy         <= '0;
            rep_x      <= '0;
            rep_y      <= '0;
            x0_q       <= '0;
            src_x      <= '0;
            src_y      <= '0;
            row_base   <= '0;
            issued_all <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_fire && in_sof) begin
                        zl      <= zl_req;
                        fx      <= XW'(1);
                        fy      <= '0;
                        wr_addr <= AW'(1);
                        busy    <= 1'b1;
                        state   <= FILL;
                    end
                end

                FILL: begin
                    if (in_fire) begin
                        if (in_sof) begin
                            zl      <= zl_req;
                            fx      <= XW'(1);
                            fy      <= '0;
                            wr_addr <= AW'(1);
                        end else begin
                            wr_addr <= wr_addr + AW'(1);
                            if (fx == X_LAST) begin
                                fx <= '0;
                                if (fy == Y_LAST) begin
                                    in_ready <= 1'b0;
                                    state    <= CALC;
                                end else begin
                                    fy <= fy + YW'(1);
                                end
                            end else begin
                                fx <= fx + XW'(1);
                            end
                        end
                    end
                end

                CALC: begin
                    x0_q       <= x0_tab[zl];
                    src_x      <= x0_tab[zl];
                    src_y      <= y0_tab[zl];
                    row_base   <= base_tab[zl];
                    ox         <= '0;
                    oy         <= '0;
                    rep_x      <= '0;
                    rep_y      <= '0;
                    issued_all <= 1'b0;
                    state      <= DRAIN;
                end

                DRAIN: begin
                    if (out_fire && out_last) begin
                        out_valid  <= 1'b0;
                        out_sof    <= 1'b0;
                        out_eol    <= 1'b0;
                        out_last   <= 1'b0;
                        busy       <= 1'b0;
                        in_ready   <= 1'b1;
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end else if (rd_en) begin
                        out_valid <= 1'b1;
                        out_sof   <= (ox == '0) && (oy == '0);
                        out_eol   <= pend_last_x;
                        out_last  <= pend_last_x && pend_last_y;
                        if (pend_last_x) begin
                            ox    <= '0;
                            rep_x <= '0;
                            src_x <= x0_q;
                            if (pend_last_y) begin
                                issued_all <= 1'b1;
                            end else begin
                                oy <= oy + YW'(1);
                                if (rep_y == zl_max) begin
                                    rep_y <= '0;
                                    // Clamp keeps the window inside the frame for odd sizes
                                    if (src_y != Y_LAST) begin
                                        src_y    <= src_y + YW'(1);
                                        row_base <= row_base + ROW_STEP;
                                    end
                                end else begin
                                    rep_y <= rep_y + ZW'(1);
                                end
                            end
                        end else begin
                            ox <= ox + XW'(1);
                            if (rep_x == zl_max) begin
                                rep_x <= '0;
                                if (src_x != X_LAST) begin
                                    src_x <= src_x + XW'(1);
                                end
                            end else begin
                                rep_x <= rep_x + ZW'(1);
                            end
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_zoom_stream.sv
// Scoreboard bench for frame_zoom_stream on an 8x4 frame: stimulus pushes hand-computed
// expected beats, a monitor pops and compares every presented output beat.
module tb_frame_zoom_stream;

    localparam int DW = 8;
    localparam int W  = 8;
    localparam int H  = 4;
    localparam int MZ = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [2:0]    zoom_sel = 3'd1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_sof;
    logic          out_eol;
    logic          out_ready = 1'b1;
    logic          busy;
    logic          frame_done;

    frame_zoom_stream #(
        .DATA_WIDTH(DW),
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .MAX_ZOOM  (MZ)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .zoom_sel  (zoom_sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .out_eol   (out_eol),
        .out_ready (out_ready),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sof;
        logic          eol;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    done_cnt = 0;
    int    beat_idx = 0;
    logic  stall_en = 1'b0;

    // Hand-computed rows for pixel = y*8 + x
    logic [DW-1:0] z2_top [W] = '{8'd10, 8'd10, 8'd11, 8'd11, 8'd12, 8'd12, 8'd13, 8'd13};
    logic [DW-1:0] z2_bot [W] = '{8'd18, 8'd18, 8'd19, 8'd19, 8'd20, 8'd20, 8'd21, 8'd21};
    logic [DW-1:0] z3_top [W] = '{8'd11, 8'd11, 8'd11, 8'd12, 8'd12, 8'd12, 8'd13, 8'd13};
    logic [DW-1:0] z3_bot [W] = '{8'd19, 8'd19, 8'd19, 8'd20, 8'd20, 8'd20, 8'd21, 8'd21};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic push_row(input logic [DW-1:0] row [W], input int oy);
        beat_t b;
        for (int ox = 0; ox < W; ox++) begin
            b.d   = row[ox];
            b.sof = (ox == 0 && oy == 0);
            b.eol = (ox == W - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic push_z2();
        push_row(z2_top, 0);
        push_row(z2_top, 1);
        push_row(z2_bot, 2);
        push_row(z2_bot, 3);
    endtask

    task automatic push_z3();
        push_row(z3_top, 0);
        push_row(z3_top, 1);
        push_row(z3_top, 2);
        push_row(z3_bot, 3);
    endtask

    task automatic push_identity(input int base);
        beat_t b;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                b.d   = DW'(base + y * W + x);
                b.sof = (x == 0 && y == 0);
                b.eol = (x == W - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat has transferred.
    task automatic send(input logic [DW-1:0] d, input logic sof);
        int n;
        n        = 0;
        in_data  = d;
        in_sof   = sof;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int base, input logic [2:0] zsel, input logic [2:0] zmid);
        zoom_sel = zsel;
        for (int i = 0; i < W * H; i++) begin
            send(DW'(base + i), i == 0);
            if (i == 0) zoom_sel = zmid;
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic wait_frame(input string name, input int done_before);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        check({name, "_frame_done_count"}, 32'(done_cnt - done_before), 32'd1);
        check({name, "_idle_busy"}, 32'(busy), 32'd0);
        check({name, "_idle_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    // Downstream ready: changes well away from the sampling edge
    initial begin
        forever begin
            @(posedge clk);
            #2;
            out_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: every presented beat (stalled or not) must match the scoreboard head
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) continue;
            if (frame_done) done_cnt++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q[0];
                    check($sformatf("beat%0d", beat_idx % (W * H)),
                          32'({out_data, out_sof, out_eol}), 32'({e.d, e.sof, e.eol}));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        beat_idx++;
                    end
                end
            end
        end
    end

    initial begin
        int d0;
        int n;

        // Reset state
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_outs", 32'({out_valid, out_data, out_sof, out_eol}), 32'd0);
        check("rst_busy_done", 32'({busy, frame_done}), 32'd0);
        #20;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // Beats without SOF in IDLE are dropped
        in_valid = 1'b1;
        in_sof   = 1'b0;
        in_data  = 8'hAA;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("idle_drop_busy", 32'(busy), 32'd0);

        // Test 1: Z=2, mid-frame zoom change to 3 must be ignored; check first-valid latency
        d0 = done_cnt;
        beat_idx = 0;
        push_z2();
        send_frame(0, 3'd2, 3'd3);
        @(negedge clk);
        check("lat_e0", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_e1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_e2", 32'(out_valid), 32'd1);
        wait_frame("z2", d0);

        // Test 2: Z=3 with in_valid+in_sof asserted during DRAIN (must be ignored)
        d0 = done_cnt;
        beat_idx = 0;
        push_z3();
        send_frame(0, 3'd3, 3'd3);
        in_valid = 1'b1;
        in_sof   = 1'b1;
        in_data  = 8'hFF;
        repeat (4) begin
            @(negedge clk);
            check("drain_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        wait_frame("z3", d0);

        // Test 3: illegal zoom values fall back to Z=1 (identity)
        d0 = done_cnt;
        beat_idx = 0;
        push_identity(40);
        send_frame(40, 3'd0, 3'd0);
        wait_frame("z0", d0);

        d0 = done_cnt;
        beat_idx = 0;
        push_identity(90);
        send_frame(90, 3'(MZ + 1), 3'(MZ + 1));
        wait_frame("z5", d0);

        // Test 4: random downstream stalls, Z=2
        d0 = done_cnt;
        beat_idx = 0;
        stall_en = 1'b1;
        push_z2();
        send_frame(0, 3'd2, 3'd2);
        wait_frame("z2_stall", d0);
        stall_en = 1'b0;

        // Test 5: SOF reasserted at fill pixel 13; restart frame uses Z=2
        d0 = done_cnt;
        beat_idx = 0;
        push_z2();
        zoom_sel = 3'd3;
        for (int i = 0; i < 13; i++) send(DW'(150 + i), i == 0);
        send_frame(0, 3'd2, 3'd2);
        wait_frame("restart", d0);

        // Test 6: reset mid-DRAIN, then a clean frame
        beat_idx = 0;
        push_z2();
        send_frame(0, 3'd2, 3'd2);
        n = 0;
        while (exp_q.size() > 20 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("pre_reset_progress", 32'(exp_q.size() <= 20), 32'd1);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("abort_outs", 32'({out_valid, out_data, out_sof, out_eol}), 32'd0);
        check("abort_ctrl", 32'({in_ready, busy, frame_done}), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_in_ready", 32'(in_ready), 32'd1);
        repeat (10) @(posedge clk);
        #1;
        check("post_reset_quiet", 32'({out_valid, busy}), 32'd0);

        d0 = done_cnt;
        beat_idx = 0;
        push_z2();
        send_frame(0, 3'd2, 3'd2);
        wait_frame("after_reset", d0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
